time_display: RTL and testbench
===============================

TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot; legal range 16 or more.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ms_i  input  10  milliseconds value, 0-999 nominal.
REQ-005 SHALL have port sec_i  input  6  seconds value, 0-59 nominal.
REQ-006 SHALL have port min_i  input  6  minutes value, 0-59 nominal.
REQ-007 SHALL have port hr_i  input  5  hours value, 0-23 nominal.
REQ-008 SHALL have ports ms_sw, s_sw, min_sw, hr_sw  input  1 each  field-select switches.
REQ-009 SHALL have port seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port an  output  4  digit anodes, an[0] rightmost, active-low.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-012 SHALL pick the field by fixed priority: ms_sw, then s_sw, then min_sw, then hr_sw; with no switch set, mode is MMSS.
REQ-013 SHALL run a free-running slot counter, 0 to REFRESH_DIV-1, and assert a one-cycle tick at terminal count.
REQ-014 SHALL advance the 2-bit digit index on each tick: 0,1,2,3, then wrap to 0.
REQ-015 SHALL sample the selected field and mode on every tick where digit index wraps 3->0, and start a conversion.
REQ-016 SHALL convert binary to BCD with a sequential shift-add-3 FSM: IDLE -> LOAD (1 cycle) -> SHIFT (one bit per cycle, 10 cycles, inputs zero-extended) -> DONE (1 cycle) -> IDLE.
REQ-017 SHALL in MMSS mode convert min_i and sec_i in two back-to-back passes: min first, then sec.
REQ-018 SHALL update the 4-digit display register only in DONE of the final pass, so a frame never shows a partial conversion.
REQ-019 SHALL ignore sample ticks that arrive while the FSM is not IDLE; the old display register stays shown.
REQ-020 SHALL saturate inputs before conversion: ms above 999 shows 999; sec or min above 59 shows 59; hr above 23 shows 23.
REQ-021 SHALL lay out digits per mode:
- ms: 3 digits on digits 2..0; digit 3 blank.
- sec / min / hr: 2 digits on digits 1..0; digits 3..2 blank.
- MMSS: min on digits 3..2, sec on digits 1..0.
REQ-022 SHALL drive dp low only on digit 2 in MMSS mode; dp is high in all other cases.
REQ-023 SHALL drive exactly one an bit low, the bit at the digit index, registered.
REQ-024 SHALL register seg from the shown digit via the standard 0-9 decode, aligned to the same cycle as an.
REQ-025 SHALL drive seg to 7'b1111111 for a blank digit.
REQ-026 SHALL let a switch change mid-frame take effect only at the next sample tick.

Reset
REQ-027 SHALL on rst set: slot counter 0, digit index 0, FSM IDLE, display register all blank, an=4'b1111, seg=7'b1111111, dp=1.
REQ-028 SHALL have rst override everything, including an in-flight conversion, which is discarded.
REQ-029 SHALL take the first sample tick after rst REFRESH_DIV*4 cycles after rst deasserts.

Verification (REFRESH_DIV=16)
REQ-030 Case ms: ms_sw=1, ms_i=987 -> after one frame plus conversion, the scan shows blank,9,8,7; dp high throughout.
REQ-031 Case MMSS: all switches 0, min_i=5, sec_i=42 -> shows 0,5,4,2; dp low only while an=4'b1011.
REQ-032 Case priority and saturation: ms_sw=1 and hr_sw=1, ms_i=1023 -> shows blank,9,9,9; then ms_sw=0, hr_i=30 -> next frame shows blank,blank,2,3.
REQ-033 Case mid-frame change: switch from s_sw to min_sw mid-frame -> the rest of that frame shows seconds; minutes appear only after the next sample tick and DONE.
REQ-034 Case reset mid-conversion: assert rst during SHIFT -> next cycle an=4'b1111, seg=7'b1111111, FSM IDLE; the first valid frame follows REQ-029.
REQ-035 Case scan: check that an cycles 1110, 1101, 1011, 0111 with exactly 16 cycles per slot, and never has two bits low.

Source files
------------

// File: rtl/time_display.sv
// Four-digit multiplexed 7-segment display for a time value.
// A free-running slot counter scans the digits. Once per frame the selected
// field is sampled and converted to BCD with a shift-add-3 FSM, then latched
// into the display register as one complete frame.
module time_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ms_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  input  logic [4:0] hr_i,
  input  logic       ms_sw,
  input  logic       s_sw,
  input  logic       min_sw,
  input  logic       hr_sw,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [3:0] Blank = 4'hF;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;
  typedef enum logic [2:0] {ModeMs, ModeSec, ModeMin, ModeHr, ModeMmss} mode_e;

  // Scan timing
  logic [CntW-1:0] r_slot_cnt;
  logic [1:0]      r_digit_idx;
  logic            w_tick;
  logic            w_sample;

  // Conversion FSM and datapath
  state_e      r_state;
  state_e      w_state_next;
  mode_e       r_mode;
  mode_e       w_sel_mode;
  logic [9:0]  w_sel_a;
  logic [9:0]  w_sel_b;
  logic [9:0]  r_val_a;
  logic [9:0]  r_val_b;
  logic        r_pass;
  logic [9:0]  r_bin;
  logic [11:0] r_bcd;
  logic [11:0] w_bcd_adj;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_first_bcd;
  logic [15:0] w_frame;

  // FSM control strobes
  logic w_start;
  logic w_load;
  logic w_shift;
  logic w_done_mid;
  logic w_done_final;

  // Saturated inputs
  logic [9:0] w_ms_sat;
  logic [5:0] w_sec_sat;
  logic [5:0] w_min_sat;
  logic [4:0] w_hr_sat;

  // Display register and decode
  logic [15:0] r_disp;
  logic        r_disp_mmss;
  logic [3:0]  w_cur_digit;
  logic [6:0]  w_seg_dec;

  assign w_tick   = (r_slot_cnt == CntLast);
  // Frame boundary: tick on the last digit slot, index about to wrap to 0.
  assign w_sample = w_tick && (r_digit_idx == 2'd3);

  // Slot counter: free-running 0..REFRESH_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt <= '0;
    end else if (w_tick) begin
      r_slot_cnt <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  // Digit index: advances on each tick, wrapping 3 -> 0 naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit_idx <= 2'd0;
    end else if (w_tick) begin
      r_digit_idx <= r_digit_idx + 2'd1;
    end
  end

  assign w_ms_sat  = (ms_i > 10'd999) ? 10'd999 : ms_i;
  assign w_sec_sat = (sec_i > 6'd59) ? 6'd59 : sec_i;
  assign w_min_sat = (min_i > 6'd59) ? 6'd59 : min_i;
  assign w_hr_sat  = (hr_i > 5'd23) ? 5'd23 : hr_i;

  // Field select by fixed switch priority; MMSS when nothing is set
  always_comb begin
    w_sel_mode = ModeMmss;
    w_sel_a    = {4'd0, w_min_sat};
    w_sel_b    = {4'd0, w_sec_sat};
    if (ms_sw) begin
      w_sel_mode = ModeMs;
      w_sel_a    = w_ms_sat;
    end else if (s_sw) begin
      w_sel_mode = ModeSec;
      w_sel_a    = {4'd0, w_sec_sat};
    end else if (min_sw) begin
      w_sel_mode = ModeMin;
      w_sel_a    = {4'd0, w_min_sat};
    end else if (hr_sw) begin
      w_sel_mode = ModeHr;
      w_sel_a    = {5'd0, w_hr_sat};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; sample ticks outside IDLE are dropped
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_sample) w_state_next = StLoad;
      StLoad:  w_state_next = StShift;
      StShift: if (r_bit_cnt == 4'd9) w_state_next = StDone;
      StDone:  w_state_next = (r_mode == ModeMmss && !r_pass) ? StLoad : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: datapath control strobes
  always_comb begin
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_done_mid   = 1'b0;
    w_done_final = 1'b0;
    case (r_state)
      StIdle:  w_start = w_sample;
      StLoad:  w_load  = 1'b1;
      StShift: w_shift = 1'b1;
      StDone: begin
        // MMSS first pass (minutes) only parks its result
        w_done_mid   = (r_mode == ModeMmss) && !r_pass;
        w_done_final = !w_done_mid;
      end
      default: ;
    endcase
  end

  // Add 3 to every BCD digit of 5 or more before the next shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion datapath: sample, load, shift-add-3, park first MMSS result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= ModeMmss;
      r_val_a     <= '0;
      r_val_b     <= '0;
      r_pass      <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_bit_cnt   <= '0;
      r_first_bcd <= '0;
    end else begin
      if (w_start) begin
        r_mode  <= w_sel_mode;
        r_val_a <= w_sel_a;
        r_val_b <= w_sel_b;
        r_pass  <= 1'b0;
      end
      if (w_load) begin
        r_bin     <= r_pass ? r_val_b : r_val_a;
        r_bcd     <= '0;
        r_bit_cnt <= '0;
      end
      if (w_shift) begin
        r_bcd     <= {w_bcd_adj[10:0], r_bin[9]};
        r_bin     <= {r_bin[8:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_done_mid) begin
        r_first_bcd <= r_bcd[7:0];
        r_pass      <= 1'b1;
      end
    end
  end

  // Digit layout of a finished conversion, digit 3 leftmost
  always_comb begin
    case (r_mode)
      ModeMs:   w_frame = {Blank, r_bcd};
      ModeMmss: w_frame = {r_first_bcd, r_bcd[7:0]};
      default:  w_frame = {Blank, Blank, r_bcd[7:0]};
    endcase
  end

  // Display register: replaced only by a complete frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp      <= {4{Blank}};
      r_disp_mmss <= 1'b0;
    end else if (w_done_final) begin
      r_disp      <= w_frame;
      r_disp_mmss <= (r_mode == ModeMmss);
    end
  end

  assign w_cur_digit = r_disp[{r_digit_idx, 2'b00} +: 4];

  // Active-low {g,f,e,d,c,b,a}; anything but 0-9 is blank
  always_comb begin
    case (w_cur_digit)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

  // Registered outputs: anode, segments and dp all aligned to the same slot
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_digit_idx);
      seg <= w_seg_dec;
      dp  <= !(r_disp_mmss && (r_digit_idx == 2'd2));
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display with REFRESH_DIV=16. A frame-level
// model derives the expected scan from the selection/saturation/layout rules
// and the conversion latency, and every cycle's an/seg/dp is compared.
module tb_time_display;

  localparam int unsigned DIV   = 16;
  localparam int          FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] ms_i;
  logic [5:0] sec_i;
  logic [5:0] min_i;
  logic [4:0] hr_i;
  logic       ms_sw, s_sw, min_sw, hr_sw;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  time_display #(.REFRESH_DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .ms_i   (ms_i),
    .sec_i  (sec_i),
    .min_i  (min_i),
    .hr_i   (hr_i),
    .ms_sw  (ms_sw),
    .s_sw   (s_sw),
    .min_sw (min_sw),
    .hr_sw  (hr_sw),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: n = rising edges since reset released; digits use 15 = blank
  int   n;
  int   done_edge;
  bit   pend;
  int   pend_time;
  int   pend_d[4];
  bit   pend_mmss;
  int   cur_d[4];
  bit   cur_mmss;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  // Segment pattern built from the set of lit segment letters
  function automatic logic [6:0] seg_of(input int d);
    string      lit;
    logic [6:0] on;
    case (d)
      0: lit = "abcdef";
      1: lit = "bc";
      2: lit = "abdeg";
      3: lit = "abcdg";
      4: lit = "bcfg";
      5: lit = "acdfg";
      6: lit = "acdefg";
      7: lit = "abc";
      8: lit = "abcdefg";
      9: lit = "abcdfg";
      default: lit = "";
    endcase
    on = '0;
    for (int i = 0; i < lit.len(); i++) on[int'(lit.getc(i)) - 97] = 1'b1;
    return ~on;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // Expected frame from the current inputs; returns conversion latency
  task automatic model_frame(output int lat);
    int v;
    int m;
    int s;
    pend_mmss = 1'b0;
    lat       = 12;
    if (ms_sw) begin
      v = (int'(ms_i) > 999) ? 999 : int'(ms_i);
      pend_d[3] = 15; pend_d[2] = v / 100; pend_d[1] = (v / 10) % 10; pend_d[0] = v % 10;
    end else if (s_sw || min_sw || hr_sw) begin
      if (s_sw)        v = (int'(sec_i) > 59) ? 59 : int'(sec_i);
      else if (min_sw) v = (int'(min_i) > 59) ? 59 : int'(min_i);
      else             v = (int'(hr_i) > 23) ? 23 : int'(hr_i);
      pend_d[3] = 15; pend_d[2] = 15; pend_d[1] = v / 10; pend_d[0] = v % 10;
    end else begin
      m = (int'(min_i) > 59) ? 59 : int'(min_i);
      s = (int'(sec_i) > 59) ? 59 : int'(sec_i);
      pend_d[3] = m / 10; pend_d[2] = m % 10; pend_d[1] = s / 10; pend_d[0] = s % 10;
      pend_mmss = 1'b1;
      lat       = 24;
    end
  endtask

  // One clock: advance the model at the rising edge, check on the falling edge
  task automatic step();
    int idx;
    int lat;
    @(posedge clk);
    if (rst) begin
      n = 0; pend = 1'b0; done_edge = -1; cur_mmss = 1'b0;
      for (int i = 0; i < 4; i++) cur_d[i] = 15;
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
    end else begin
      n++;
      idx     = ((n - 1) / DIV) % 4;
      exp_an  = ~(4'b0001 << idx);
      exp_seg = seg_of(cur_d[idx]);
      exp_dp  = !(cur_mmss && idx == 2);
      if (pend && pend_time == n) begin
        cur_d = pend_d; cur_mmss = pend_mmss; pend = 1'b0;
      end
      if (n % FRAME == 0 && n > done_edge) begin
        model_frame(lat);
        pend = 1'b1; pend_time = n + lat; done_edge = pend_time;
      end
    end
    @(negedge clk);
    chk("an", {28'd0, an}, {28'd0, exp_an});
    chk("seg", {25'd0, seg}, {25'd0, exp_seg});
    chk("dp", {31'd0, dp}, {31'd0, exp_dp});
    if (!rst) chk("an_one_low", 32'($countones(~an)), 32'd1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    n = 0; done_edge = -1; pend = 1'b0; cur_mmss = 1'b0;
    for (int i = 0; i < 4; i++) cur_d[i] = 15;
    rst = 1'b1;
    ms_i = '0; sec_i = '0; min_i = '0; hr_i = '0;
    ms_sw = 1'b0; s_sw = 1'b0; min_sw = 1'b0; hr_sw = 1'b0;
    @(negedge clk);
    run(3);
    rst = 1'b0;

    // Milliseconds: blank,9,8,7
    ms_sw = 1'b1; ms_i = 10'd987;
    run(3 * FRAME);

    // MMSS: 0,5,4,2 with dp on digit 2
    ms_sw = 1'b0; min_i = 6'd5; sec_i = 6'd42;
    run(3 * FRAME);

    // Priority and saturation
    ms_sw = 1'b1; hr_sw = 1'b1; ms_i = 10'd1023;
    run(2 * FRAME);
    ms_sw = 1'b0; hr_i = 5'd30;
    run(2 * FRAME);

    // Mid-frame switch change from seconds to minutes
    hr_sw = 1'b0; s_sw = 1'b1; sec_i = 6'd37; min_i = 6'd12;
    run(2 * FRAME);
    while (n % FRAME != 30) step();
    s_sw = 1'b0; min_sw = 1'b1;
    run(2 * FRAME + 10);

    // Reset during SHIFT of an MMSS conversion
    min_sw = 1'b0; min_i = 6'd47; sec_i = 6'd8;
    while (n % FRAME != 5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(3 * FRAME);

    // Randomized fields, switches, out-of-range values and occasional resets
    for (int k = 0; k < 24; k++) begin
      ms_i   = 10'($urandom_range(0, 1023));
      sec_i  = 6'($urandom_range(0, 63));
      min_i  = 6'($urandom_range(0, 63));
      hr_i   = 5'($urandom_range(0, 31));
      ms_sw  = ($urandom_range(0, 3) == 0);
      s_sw   = ($urandom_range(0, 2) == 0);
      min_sw = ($urandom_range(0, 2) == 0);
      hr_sw  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 2));
        rst = 1'b0;
      end
      run($urandom_range(20, 160));
    end
    run(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
